// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the true dual-port RAM block:
//   state_t      clear-sequencer states (CLEAR after reset, READY afterwards)
//   RD_LAT_MIN/MAX  legal read-latency range
//   be_merge     per-byte merge of a new word over an old word
// be_merge works on a fixed 64-bit container; callers zero-extend their
// word and truncate the result, so one function serves every DATA_W <= 64.
// ---------------------------------------------------------------------------
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    localparam int MERGE_W    = 64;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]    old_w,
        input logic [MERGE_W-1:0]    new_w,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// ---------------------------------------------------------------------------
// dpram_rd_pipe
// Per-port read-return pipeline of RD_LAT register stages.
//   clk, rst_n     clock, asynchronous active-low reset (flushes all stages)
//   in_valid       read accepted this cycle
//   in_data        word read from the array this cycle
//   out_valid      1-cycle strobe, RD_LAT cycles after in_valid
//   out_data       returned word; holds its last value while out_valid is low
// Each data stage loads only when the stage before it carries a valid word,
// which gives the hold-last-value behaviour without an extra register.
// ---------------------------------------------------------------------------
module dpram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] dat [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/dpram_tdp_param.sv
// ---------------------------------------------------------------------------
// dpram_tdp_param
// True dual-port RAM, one clock, two independent read/write ports, with a
// post-reset clear sequencer, RD_LAT-cycle reads and collision detection.
// Ports (x = a or b):
//   clk, rst_n        clock, asynchronous active-low reset
//   x_en, x_we        request / write-not-read
//   x_addr, x_wdata   address, write data
//   x_be              byte enables for writes
//   x_rdata, x_rvalid read data and its 1-cycle valid strobe
//   collision         same address on both ports with at least one write,
//                     reported with the same latency as read data
//   init_busy         clear sequencer running, requests ignored
//   state_dbg         clear-sequencer state (CLEAR=0, READY=1)
// Request protocol: a request is taken on every rising edge where x_en=1 and
// init_busy=0; there is no back-pressure. Reads return exactly once, in
// order, RD_LAT cycles later; writes never return anything.
// Build option: define DPRAM_WR_FWD_EN to forward a same-cycle write from
// the other port into the read result (write-first); otherwise read-first.
// ---------------------------------------------------------------------------
module dpram_tdp_param
    import dpram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [BE_W-1:0]   a_be,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [BE_W-1:0]   b_be,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              collision,
    output logic              init_busy,
    output logic              state_dbg
);

    // Out-of-range latency values are clamped to the legal range.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- clear sequencer ----------------
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == CLEAR) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST_ADDR) begin
                state_nxt = READY;
            end
        end
    end

    // state is a register, so init_busy is a registered output.
    assign init_busy = (state == CLEAR);
    assign state_dbg = state;

    // ---------------- request decode ----------------
    logic a_in, b_in, same, a_wr, b_wr, a_rd, b_rd, coll_now;

    assign a_in     = ({1'b0, a_addr} < DEPTH_L);
    assign b_in     = ({1'b0, b_addr} < DEPTH_L);
    assign same     = (a_addr == b_addr);
    assign a_wr     = a_en && a_we && !init_busy && a_in;
    assign b_wr     = b_en && b_we && !init_busy && b_in;
    assign a_rd     = a_en && !a_we && !init_busy;
    assign b_rd     = b_en && !b_we && !init_busy;
    assign coll_now = a_en && b_en && !init_busy && same && (a_we || b_we);

    // ---------------- write merge / read select ----------------
    logic [DATA_W-1:0] a_old, b_old, a_base, a_new, b_new, a_rd_data, b_rd_data;

    always_comb begin
        a_old  = a_in ? mem[a_addr] : '0;
        b_old  = b_in ? mem[b_addr] : '0;
        b_new  = DATA_W'(be_merge(MERGE_W'(b_old), MERGE_W'(b_wdata), MERGE_BE_W'(b_be)));
        // On a double write to one word, A's bytes go over B's merged word,
        // so A wins per byte and B keeps the bytes only it enabled.
        a_base = (b_wr && same) ? b_new : a_old;
        a_new  = DATA_W'(be_merge(MERGE_W'(a_base), MERGE_W'(a_wdata), MERGE_BE_W'(a_be)));
`ifdef DPRAM_WR_FWD_EN
        a_rd_data = (b_wr && same) ? b_new : a_old;
        b_rd_data = (a_wr && same) ? a_new : b_old;
`else
        a_rd_data = a_old;
        b_rd_data = b_old;
`endif
    end

    // Array has no reset; the clear sequencer zeroes it after reset.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[ptr] <= '0;
        end else begin
            if (b_wr) begin
                mem[b_addr] <= b_new;
            end
            if (a_wr) begin
                mem[a_addr] <= a_new;
            end
        end
    end

    // ---------------- read return ----------------
    dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_rd_pipe_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_rd),
        .in_data   (a_rd_data),
        .out_valid (a_rvalid),
        .out_data  (a_rdata)
    );

    dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_rd_pipe_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_rd),
        .in_data   (b_rd_data),
        .out_valid (b_rvalid),
        .out_data  (b_rdata)
    );

    // Collision strobe delayed to line up with the read-data strobes.
    logic [LAT-1:0] coll_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_sr <= '0;
        end else begin
            coll_sr[0] <= coll_now;
            for (int i = 1; i < LAT; i++) begin
                coll_sr[i] <= coll_sr[i-1];
            end
        end
    end

    assign collision = coll_sr[LAT-1];

endmodule

// File: tb/tb_dpram_tdp_param.sv
// ---------------------------------------------------------------------------
// tb_dpram_tdp_param
// Two instances share clock and reset:
//   dut0: DATA_W=8,  DEPTH=32, RD_LAT=1  (table-driven port/collision tests)
//   dut1: DATA_W=16, DEPTH=24, RD_LAT=2  (byte enables, range, latency, reset)
// Expected words are pushed to a queue when a request is driven and popped
// when the result is due, then compared with the DUT outputs on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_dpram_tdp_param;

`ifdef DPRAM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- dut0 signals ----------------
    logic       a0_en = 0, a0_we = 0, a0_be = 0, b0_en = 0, b0_we = 0, b0_be = 0;
    logic [4:0] a0_addr = 0, b0_addr = 0;
    logic [7:0] a0_wdata = 0, b0_wdata = 0, a0_rdata, b0_rdata;
    logic       a0_rvalid, b0_rvalid, coll0, busy0, state0;

    // ---------------- dut1 signals ----------------
    logic        a1_en = 0, a1_we = 0, b1_en = 0, b1_we = 0;
    logic [1:0]  a1_be = 0, b1_be = 0;
    logic [4:0]  a1_addr = 0, b1_addr = 0;
    logic [15:0] a1_wdata = 0, b1_wdata = 0, a1_rdata, b1_rdata;
    logic        a1_rvalid, b1_rvalid, coll1, busy1, state1;

    dpram_tdp_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a0_en), .a_we(a0_we), .a_addr(a0_addr), .a_wdata(a0_wdata), .a_be(a0_be),
        .a_rdata(a0_rdata), .a_rvalid(a0_rvalid),
        .b_en(b0_en), .b_we(b0_we), .b_addr(b0_addr), .b_wdata(b0_wdata), .b_be(b0_be),
        .b_rdata(b0_rdata), .b_rvalid(b0_rvalid),
        .collision(coll0), .init_busy(busy0), .state_dbg(state0)
    );

    dpram_tdp_param #(.DATA_W(16), .ADDR_W(5), .DEPTH(24), .RD_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a1_en), .a_we(a1_we), .a_addr(a1_addr), .a_wdata(a1_wdata), .a_be(a1_be),
        .a_rdata(a1_rdata), .a_rvalid(a1_rvalid),
        .b_en(b1_en), .b_we(b1_we), .b_addr(b1_addr), .b_wdata(b1_wdata), .b_be(b1_be),
        .b_rdata(b1_rdata), .b_rvalid(b1_rvalid),
        .collision(coll1), .init_busy(busy1), .state_dbg(state1)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       ae, awe; logic [4:0] aa; logic [7:0] ad; logic abe;
        logic       be, bwe; logic [4:0] ba; logic [7:0] bd; logic bbe;
        logic       xav; logic [7:0] xad; logic xbv; logic [7:0] xbd; logic xc;
    } vec_t;

    function automatic vec_t mkv(input int ae, awe, aa, ad, abe, be, bwe, ba, bd, bbe,
                                 input int xav, xad, xbv, xbd, xc);
        vec_t v;
        v.ae = 1'(ae); v.awe = 1'(awe); v.aa = 5'(aa); v.ad = 8'(ad); v.abe = 1'(abe);
        v.be = 1'(be); v.bwe = 1'(bwe); v.ba = 5'(ba); v.bd = 8'(bd); v.bbe = 1'(bbe);
        v.xav = 1'(xav); v.xad = 8'(xad); v.xbv = 1'(xbv); v.xbd = 8'(xbd); v.xc = 1'(xc);
        return v;
    endfunction

    // ---------------- scoreboards ----------------
    logic [18:0] exp_q0[$];   // {a_rvalid, a_rdata, b_rvalid, b_rdata, collision}
    logic [16:0] exp_q1[$];   // {a_rvalid, a_rdata}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // dut0: one cycle per vector, result due at the next falling edge.
    task automatic drive0(input vec_t v);
        logic [18:0] e;
        a0_en = v.ae; a0_we = v.awe; a0_addr = v.aa; a0_wdata = v.ad; a0_be = v.abe;
        b0_en = v.be; b0_we = v.bwe; b0_addr = v.ba; b0_wdata = v.bd; b0_be = v.bbe;
        exp_q0.push_back({v.xav, v.xad, v.xbv, v.xbd, v.xc});
        @(negedge clk);
        e = exp_q0.pop_front();
        chk("a0_rvalid", 32'(a0_rvalid), 32'(e[18]));
        chk("a0_rdata",  32'(a0_rdata),  32'(e[17:10]));
        chk("b0_rvalid", 32'(b0_rvalid), 32'(e[9]));
        chk("b0_rdata",  32'(b0_rdata),  32'(e[8:1]));
        chk("collision0", 32'(coll0),    32'(e[0]));
    endtask

    // dut1 port A: result of the request driven one call earlier is due now.
    task automatic drive1(input logic en, input logic we, input logic [4:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          input logic xv, input logic [15:0] xd);
        logic [16:0] e;
        a1_en = en; a1_we = we; a1_addr = addr; a1_wdata = wd; a1_be = be;
        exp_q1.push_back({xv, xd});
        @(negedge clk);
        if (exp_q1.size() >= 2) begin
            e = exp_q1.pop_front();
            chk("a1_rvalid", 32'(a1_rvalid), 32'(e[16]));
            chk("a1_rdata",  32'(a1_rdata),  32'(e[15:0]));
        end
    endtask

    task automatic idle_all();
        a0_en = 0; a0_we = 0; b0_en = 0; b0_we = 0;
        a1_en = 0; a1_we = 0; b1_en = 0; b1_we = 0;
    endtask

    task automatic chk_reset_state();
        chk("rst a0_rdata", 32'(a0_rdata), 0);
        chk("rst a0_rvalid", 32'(a0_rvalid), 0);
        chk("rst b0_rdata", 32'(b0_rdata), 0);
        chk("rst b0_rvalid", 32'(b0_rvalid), 0);
        chk("rst collision0", 32'(coll0), 0);
        chk("rst init_busy0", 32'(busy0), 1);
        chk("rst a1_rdata", 32'(a1_rdata), 0);
        chk("rst a1_rvalid", 32'(a1_rvalid), 0);
        chk("rst init_busy1", 32'(busy1), 1);
    endtask

    // Called right after reset release on a falling edge; a read held on
    // dut0 port A throughout must be ignored while clearing.
    task automatic wait_ready();
        a0_en = 1; a0_we = 0; a0_addr = 5'd5;
        for (int i = 0; i <= 32; i++) begin
            chk("init_busy0", 32'(busy0), 32'(i < 32));
            chk("init_busy1", 32'(busy1), 32'(i < 24));
            chk("state0", 32'(state0), 32'(i >= 32));
            chk("a0_rvalid while busy", 32'(a0_rvalid), 0);
            @(negedge clk);
        end
        a0_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        tbl[0]  = mkv(1,1, 5,'hAA,1,  0,0, 0,'h00,0,  0,'h00, 0,'h00, 0);
        tbl[1]  = mkv(0,0, 0,'h00,0,  1,0, 5,'h00,0,  0,'h00, 1,'hAA, 0);
        tbl[2]  = mkv(1,1, 7,'h11,1,  1,1, 7,'h22,1,  0,'h00, 0,'hAA, 1);
        tbl[3]  = mkv(1,0, 7,'h00,0,  0,0, 0,'h00,0,  1,'h11, 0,'hAA, 0);
        tbl[4]  = mkv(1,1, 9,'h55,1,  0,0, 0,'h00,0,  0,'h11, 0,'hAA, 0);
        tbl[5]  = mkv(1,1, 9,'hCC,1,  1,0, 9,'h00,0,  0,'h11, 1,FWD ? 'hCC : 'h55, 1);
        tbl[6]  = mkv(0,0, 0,'h00,0,  1,0, 9,'h00,0,  0,'h11, 1,'hCC, 0);
        tbl[7]  = mkv(1,0, 5,'h00,0,  1,0, 5,'h00,0,  1,'hAA, 1,'hAA, 0);
        tbl[8]  = mkv(1,1,31,'h77,1,  1,0, 0,'h00,0,  0,'hAA, 1,'h00, 0);
        tbl[9]  = mkv(1,1,31,'h99,0,  1,0,31,'h00,0,  0,'hAA, 1,'h77, 1);
        tbl[10] = mkv(1,0,31,'h00,0,  1,1, 2,'h33,1,  1,'h77, 0,'h77, 0);
        tbl[11] = mkv(1,0, 2,'h00,0,  1,0, 2,'h00,0,  1,'h33, 1,'h33, 0);
        tbl[12] = mkv(0,1, 2,'hFF,1,  0,0, 0,'h00,0,  0,'h33, 0,'h33, 0);
        tbl[13] = mkv(1,0, 2,'h00,0,  0,0, 0,'h00,0,  1,'h33, 0,'h33, 0);
        tbl[14] = mkv(1,0, 2,'h00,0,  1,1, 2,'h44,1,  1,FWD ? 'h44 : 'h33, 0,'h33, 1);
        tbl[15] = mkv(1,0, 2,'h00,0,  0,0, 0,'h00,0,  1,'h44, 0,'h33, 0);

        // ---- reset state and clear sequencing ----
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        wait_ready();

        // ---- whole array reads back cleared (both ports, random order) ----
        for (int i = 0; i < 32; i++) begin
            int ra;
            ra = (i == 0) ? 0 : int'($urandom_range(31, 0));
            drive0(mkv(1,0,i,0,0, 1,0,31-i,0,0, 1,0, 1,0, 0));
            drive0(mkv(1,0,ra,0,0, 0,0,0,0,0, 1,0, 0,0, 0));
        end

        // ---- table: writes, byte enables, collisions, holds ----
        for (int i = 0; i < 16; i++) begin
            drive0(tbl[i]);
        end
        idle_all();

        // ---- dut1: byte enables, address range, RD_LAT=2 ordering ----
        drive1(1,1, 3,16'h1234,2'b11, 0,16'h0000);
        drive1(1,1, 3,16'hFF00,2'b10, 0,16'h0000);
        drive1(1,0, 3,16'h0000,2'b00, 1,16'hFF34);
        drive1(1,1, 0,16'hABCD,2'b01, 0,16'hFF34);
        drive1(1,1, 1,16'h5678,2'b11, 0,16'hFF34);
        drive1(1,1, 2,16'h9ABC,2'b11, 0,16'hFF34);
        drive1(1,0, 0,16'h0000,2'b00, 1,16'h00CD);
        drive1(1,0, 1,16'h0000,2'b00, 1,16'h5678);
        drive1(1,0, 2,16'h0000,2'b00, 1,16'h9ABC);
        drive1(1,0, 3,16'h0000,2'b00, 1,16'hFF34);
        drive1(1,0,30,16'h0000,2'b00, 1,16'h0000);
        drive1(1,1,23,16'hBEEF,2'b11, 0,16'h0000);
        drive1(1,1,24,16'hDEAD,2'b11, 0,16'h0000);
        drive1(1,0,23,16'h0000,2'b00, 1,16'hBEEF);
        drive1(1,0,24,16'h0000,2'b00, 1,16'h0000);
        drive1(1,0, 0,16'h0000,2'b00, 1,16'h00CD);
        drive1(0,0, 0,16'h0000,2'b00, 0,16'h00CD);
        // back-to-back reads, then reset with the pipeline still full
        drive1(1,0, 0,16'h0000,2'b00, 1,16'h00CD);
        drive1(1,0, 1,16'h0000,2'b00, 1,16'h5678);
        drive1(1,0, 2,16'h0000,2'b00, 1,16'h9ABC);
        drive1(1,0, 3,16'h0000,2'b00, 1,16'hFF34);
        rst_n = 1'b0;
        #1;
        chk("mid-stream a1_rvalid", 32'(a1_rvalid), 0);
        chk_reset_state();
        exp_q1.delete();
        idle_all();
        @(negedge clk);
        chk("flushed a1_rvalid", 32'(a1_rvalid), 0);

        // ---- reset in the middle of CLEAR restarts from address 0 ----
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid-clear init_busy0", 32'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();

        // ---- previously written words are cleared again ----
        drive0(mkv(1,0,5,0,0, 1,0,31,0,0, 1,'h00, 1,'h00, 0));
        drive0(mkv(1,0,9,0,0, 1,0, 2,0,0, 1,'h00, 1,'h00, 0));
        drive1(1,0, 3,16'h0000,2'b00, 1,16'h0000);
        drive1(1,0,23,16'h0000,2'b00, 1,16'h0000);
        drive1(0,0, 0,16'h0000,2'b00, 0,16'h0000);
        drive1(0,0, 0,16'h0000,2'b00, 0,16'h0000);
        exp_q1.delete();
        idle_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
